// File: rtl/arp_pkg.sv
// Shared ARP/Ethernet constants, FSM state type and frame byte generator.
// Frames are 42 bytes starting at the destination MAC; multi-byte fields go out MSB first.
package arp_pkg;

    localparam int ARP_FRAME_LEN = 42;

    localparam logic [15:0] ETHERTYPE_ARP = 16'h0806;
    localparam logic [15:0] HTYPE_ETH     = 16'h0001;
    localparam logic [15:0] PTYPE_IPV4    = 16'h0800;
    localparam logic [7:0]  HLEN_ETH      = 8'h06;
    localparam logic [7:0]  PLEN_IPV4     = 8'h04;
    localparam logic [15:0] OPER_REQUEST  = 16'h0001;
    localparam logic [15:0] OPER_REPLY    = 16'h0002;

    localparam int OFF_DST       = 0;
    localparam int OFF_SRC       = 6;
    localparam int OFF_ETHERTYPE = 12;
    localparam int OFF_HTYPE     = 14;
    localparam int OFF_PTYPE     = 16;
    localparam int OFF_HLEN      = 18;
    localparam int OFF_PLEN      = 19;
    localparam int OFF_OPER      = 20;
    localparam int OFF_SHA       = 22;
    localparam int OFF_SPA       = 28;
    localparam int OFF_THA       = 32;
    localparam int OFF_TPA       = 38;

    typedef enum logic [1:0] {
        StIdle,
        StTxWait,
        StTxSend,
        StWaitReply
    } arp_req_state_t;

    // Byte idx of an ARP frame; the Ethernet source MAC doubles as the sender MAC and THA is zero.
    function automatic logic [7:0] arp_frame_byte(input logic [5:0]  idx,
                                                  input logic [15:0] oper,
                                                  input logic [47:0] dst,
                                                  input logic [47:0] sha,
                                                  input logic [31:0] spa,
                                                  input logic [31:0] tpa);
        int i;
        logic [7:0] b;
        i = int'(idx);
        b = 8'h00;
        if (i < OFF_SRC)              b = 8'(dst >> (8 * (OFF_SRC - 1 - i)));
        else if (i < OFF_ETHERTYPE)   b = 8'(sha >> (8 * (OFF_ETHERTYPE - 1 - i)));
        else if (i < OFF_HTYPE)       b = 8'(ETHERTYPE_ARP >> (8 * (OFF_HTYPE - 1 - i)));
        else if (i < OFF_PTYPE)       b = 8'(HTYPE_ETH >> (8 * (OFF_PTYPE - 1 - i)));
        else if (i < OFF_HLEN)        b = 8'(PTYPE_IPV4 >> (8 * (OFF_HLEN - 1 - i)));
        else if (i == OFF_HLEN)       b = HLEN_ETH;
        else if (i == OFF_PLEN)       b = PLEN_IPV4;
        else if (i < OFF_SHA)         b = 8'(oper >> (8 * (OFF_SHA - 1 - i)));
        else if (i < OFF_SPA)         b = 8'(sha >> (8 * (OFF_SPA - 1 - i)));
        else if (i < OFF_THA)         b = 8'(spa >> (8 * (OFF_THA - 1 - i)));
        else if (i < OFF_TPA)         b = 8'h00;
        else if (i < ARP_FRAME_LEN)   b = 8'(tpa >> (8 * (ARP_FRAME_LEN - 1 - i)));
        return b;
    endfunction

endpackage

// File: rtl/arp_request_block_parser.sv
// Continuous RX parser: checks each byte of an incoming frame against the expected ARP reply
// and raises a one-cycle match (with the captured sender MAC) on the first idle cycle after it.
module arp_reply_parser
    import arp_pkg::*;
(
    input  logic        clk,
    input  logic        areset,
    input  logic        data_valid_rx,
    input  logic [7:0]  data_rx,
    input  logic [47:0] my_mac,
    input  logic [31:0] my_ipv4,
    input  logic [31:0] target_ip,
    output logic        match,
    output logic [47:0] mac
);

    logic [5:0]  cnt_q;
    logic        in_frame_q;
    logic        dst_bcast_q;
    logic        dst_mine_q;
    logic        fields_ok_q;
    logic [47:0] mac_q;

    int          idx;
    logic [7:0]  exp_byte;
    logic        checked;

    always_comb begin
        idx      = int'(cnt_q);
        exp_byte = arp_frame_byte(cnt_q, OPER_REPLY, my_mac, 48'h0, target_ip, my_ipv4);
        checked  = (idx >= OFF_ETHERTYPE && idx < OFF_SHA) ||
                   (idx >= OFF_SPA && idx < OFF_THA) ||
                   (idx >= OFF_TPA && idx < ARP_FRAME_LEN);
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            cnt_q       <= '0;
            in_frame_q  <= 1'b0;
            dst_bcast_q <= 1'b1;
            dst_mine_q  <= 1'b1;
            fields_ok_q <= 1'b1;
            mac_q       <= '0;
        end else if (data_valid_rx) begin
            in_frame_q <= 1'b1;
            if (cnt_q != 6'd63) cnt_q <= cnt_q + 6'd1;
            if (idx < OFF_SRC) begin
                dst_bcast_q <= dst_bcast_q & (data_rx == 8'hFF);
                dst_mine_q  <= dst_mine_q & (data_rx == exp_byte);
            end
            if (checked && data_rx != exp_byte) fields_ok_q <= 1'b0;
            if (idx >= OFF_SHA && idx < OFF_SPA) mac_q <= {mac_q[39:0], data_rx};
        end else begin
            cnt_q       <= '0;
            in_frame_q  <= 1'b0;
            dst_bcast_q <= 1'b1;
            dst_mine_q  <= 1'b1;
            fields_ok_q <= 1'b1;
        end
    end

    assign match = in_frame_q && !data_valid_rx && fields_ok_q && (dst_bcast_q || dst_mine_q) &&
                   (idx >= ARP_FRAME_LEN);
    assign mac   = mac_q;

endmodule

// File: rtl/arp_request_block.sv
// ARP initiator: broadcasts a request for RESOLVE_IP, waits for the matching reply and
// retries on RX-idle timeout, pulsing RESOLVE_FAIL once every attempt has expired.
module arp_request_block
    import arp_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter int unsigned MAX_RETRIES    = 3
) (
    input  logic        CLK,
    input  logic        ARESET,
    input  logic [47:0] MY_MAC,
    input  logic [31:0] MY_IPV4,
    input  logic        RESOLVE_REQ,
    input  logic [31:0] RESOLVE_IP,
    output logic        READY,
    output logic        RESOLVED_VALID,
    output logic [47:0] RESOLVED_MAC,
    output logic        RESOLVE_FAIL,
    input  logic        DATA_VALID_RX,
    input  logic [7:0]  DATA_RX,
    output logic        DATA_VALID_TX,
    output logic [7:0]  DATA_TX,
    input  logic        DATA_ACK_TX
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned AW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
    localparam logic [TW-1:0] TMO_LAST     = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [AW-1:0] ATTEMPT_LAST = AW'(MAX_RETRIES);

    arp_req_state_t state_q;
    logic [31:0]    target_q;
    logic [5:0]     tx_idx_q;
    logic [TW-1:0]  tmo_q;
    logic [AW-1:0]  attempt_q;
    logic [7:0]     next_tx_byte;
    logic           match;
    logic [47:0]    reply_mac;

    arp_reply_parser u_parser (
        .clk           (CLK),
        .areset        (ARESET),
        .data_valid_rx (DATA_VALID_RX),
        .data_rx       (DATA_RX),
        .my_mac        (MY_MAC),
        .my_ipv4       (MY_IPV4),
        .target_ip     (target_q),
        .match         (match),
        .mac           (reply_mac)
    );

    always_comb begin
        next_tx_byte = arp_frame_byte(tx_idx_q + 6'd1, OPER_REQUEST, {48{1'b1}}, MY_MAC, MY_IPV4,
                                      target_q);
    end

    always_ff @(posedge CLK or posedge ARESET) begin
        if (ARESET) begin
            state_q        <= StIdle;
            target_q       <= '0;
            tx_idx_q       <= '0;
            tmo_q          <= '0;
            attempt_q      <= '0;
            READY          <= 1'b1;
            RESOLVED_VALID <= 1'b0;
            RESOLVED_MAC   <= '0;
            RESOLVE_FAIL   <= 1'b0;
            DATA_VALID_TX  <= 1'b0;
            DATA_TX        <= 8'h00;
        end else begin
            RESOLVED_VALID <= 1'b0;
            RESOLVE_FAIL   <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (RESOLVE_REQ) begin
                        target_q      <= RESOLVE_IP;
                        attempt_q     <= '0;
                        tx_idx_q      <= '0;
                        READY         <= 1'b0;
                        DATA_VALID_TX <= 1'b1;
                        DATA_TX       <= 8'hFF;
                        state_q       <= StTxWait;
                    end
                end
                StTxWait: begin
                    if (DATA_ACK_TX) begin
                        tx_idx_q <= 6'd1;
                        DATA_TX  <= next_tx_byte;
                        state_q  <= StTxSend;
                    end
                end
                StTxSend: begin
                    if (tx_idx_q == 6'(ARP_FRAME_LEN - 1)) begin
                        DATA_VALID_TX <= 1'b0;
                        DATA_TX       <= 8'h00;
                        tmo_q         <= '0;
                        state_q       <= StWaitReply;
                    end else begin
                        tx_idx_q <= tx_idx_q + 6'd1;
                        DATA_TX  <= next_tx_byte;
                    end
                end
                StWaitReply: begin
                    // A reply ending on the expiring cycle still wins over the timeout.
                    if (match) begin
                        RESOLVED_VALID <= 1'b1;
                        RESOLVED_MAC   <= reply_mac;
                        READY          <= 1'b1;
                        state_q        <= StIdle;
                    end else if (!DATA_VALID_RX) begin
                        if (tmo_q == TMO_LAST) begin
                            if (attempt_q == ATTEMPT_LAST) begin
                                RESOLVE_FAIL <= 1'b1;
                                READY        <= 1'b1;
                                state_q      <= StIdle;
                            end else begin
                                attempt_q     <= attempt_q + 1'b1;
                                tx_idx_q      <= '0;
                                DATA_VALID_TX <= 1'b1;
                                DATA_TX       <= 8'hFF;
                                state_q       <= StTxWait;
                            end
                        end else begin
                            tmo_q <= tmo_q + 1'b1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/arp_request_block.md
# arp_request_block

ARP initiator: on request, transmits a broadcast Ethernet/ARP request for a target IPv4 address, waits for the matching ARP reply, and reports the resolved MAC. Retries on timeout and signals failure after the last attempt. It is the counterpart of `arp_response_block` and uses the same byte-stream RX/TX interfaces: 42-byte frames starting at the destination MAC, with no preamble and no FCS.

## Interface
- `TIMEOUT_CYCLES`, default 1000000: number of RX-idle clock cycles to wait for a reply per attempt.
- `MAX_RETRIES`, default 3: retransmissions after the first attempt. Total attempts = 1 + `MAX_RETRIES`.

- `CLK`  in  1  single clock for all logic.
- `ARESET`  in  1  asynchronous, active-high reset.
- `MY_MAC`  in  48  own MAC; static while not `READY`.
- `MY_IPV4`  in  32  own IPv4; static while not `READY`.
- `RESOLVE_REQ`  in  1  start resolution; accepted only when `READY`=1.
- `RESOLVE_IP`  in  32  target IPv4; sampled with an accepted `RESOLVE_REQ`.
- `READY`  out  1  idle and able to accept a request.
- `RESOLVED_VALID`  out  1  one-cycle pulse: `RESOLVED_MAC` is valid.
- `RESOLVED_MAC`  out  48  sender MAC from the matching reply; held until the next success.
- `RESOLVE_FAIL`  out  1  one-cycle pulse: all attempts timed out.
- `DATA_VALID_RX`  in  1  RX frame byte valid; high for the whole contiguous frame.
- `DATA_RX`  in  8  RX frame byte.
- `DATA_VALID_TX`  out  1  TX frame in progress.
- `DATA_TX`  out  8  TX frame byte.
- `DATA_ACK_TX`  in  1  one-cycle pulse: MAC accepted byte 0.

## Operation
- States:
  - IDLE → TX_WAIT on an accepted `RESOLVE_REQ`. `RESOLVE_IP` is latched and the attempt counter is cleared.
  - TX_WAIT → TX_SEND on `DATA_ACK_TX`=1.
  - TX_SEND → WAIT_REPLY after byte 41.
  - WAIT_REPLY → IDLE on a matching reply or on final timeout. On a non-final timeout, WAIT_REPLY → TX_WAIT and the attempt counter increments.
- TX frame, bytes 0..41:
  - FF×6
  - `MY_MAC`
  - 08 06
  - 00 01
  - 08 00
  - 06
  - 04
  - 00 01
  - `MY_MAC`
  - `MY_IPV4`
  - 00×6
  - target IP
- Multi-byte fields are sent MSB first.
- RX parser runs continuously. It counts bytes while `DATA_VALID_RX`=1; bytes beyond 41 (padding) are ignored.
- A frame matches when all of the following hold:
  - length ≥ 42
  - bytes 0-5 are FF×6 or `MY_MAC`
  - bytes 12-13 are 08 06
  - bytes 14-21 are 00 01 08 00 06 04 00 02
  - bytes 28-31 equal the target IP
  - bytes 38-41 equal `MY_IPV4`
- Bytes 22-27 of a matching frame are captured as the candidate MAC.
- A match is evaluated on the first cycle with `DATA_VALID_RX`=0 after a frame. It is acted on only in WAIT_REPLY; in any other state it is dropped.
- Timeout counter:
  - cleared on entry to WAIT_REPLY
  - increments on each WAIT_REPLY cycle with `DATA_VALID_RX`=0
  - frozen while `DATA_VALID_RX`=1
  - expires at `TIMEOUT_CYCLES`
- If a match evaluation and timeout expiry occur on the same cycle, the match wins.
- `RESOLVE_REQ` while `READY`=0 is ignored and is not queued.

## Timing
- Reset values:
  - `READY`=1
  - `DATA_VALID_TX`=0, `DATA_TX`=00
  - `RESOLVED_VALID`=0, `RESOLVE_FAIL`=0
  - `RESOLVED_MAC`=0
- Reset is asynchronous: asserting `ARESET` mid-operation forces these values immediately, aborts any frame, and discards any partial RX parse.
- All outputs are registered.
- TX start: `RESOLVE_REQ` sampled at edge N → `READY`=0, `DATA_VALID_TX`=1, `DATA_TX`=FF after edge N.
- TX byte 0 handshake:
  - Byte 0 is held until `DATA_ACK_TX` is sampled high at edge A.
  - Bytes 1..41 appear after edges A..A+40, one per cycle.
  - `DATA_VALID_TX`=0 after edge A+41.
- `DATA_ACK_TX` outside TX_WAIT is ignored.
- Reply: first low `DATA_VALID_RX` sampled at edge M → after edge M, `RESOLVED_VALID`=1 for one cycle, `RESOLVED_MAC` is updated, and `READY`=1.
- Final timeout: after the expiring edge, `RESOLVE_FAIL`=1 for one cycle and `READY`=1.
- Retry: `DATA_VALID_TX`=1 with byte 0 after the expiring edge.
- Counter width is $clog2(`TIMEOUT_CYCLES`+1). The RX byte counter saturates at 63.

## Structure
- Shared package `arp_pkg`, holding:
  - `ARP_FRAME_LEN`=42
  - `ETHERTYPE_ARP`, `HTYPE_ETH`, `PTYPE_IPV4`, `HLEN_ETH`, `PLEN_IPV4`
  - `OPER_REQUEST`, `OPER_REPLY`
  - byte-offset constants
  - state enum `arp_req_state_t`
- One sub-module, `arp_reply_parser`: RX byte counter, field compare, MAC capture, and a one-cycle `match`/`mac` output at frame end.
- Top level holds the FSM, TX byte mux, timeout counter and attempt counter.

## Test plan
- Basic TX: `MY_MAC`=000223010203, `MY_IPV4`=C0A80102, request C0A80101, ack 5 cycles later. Required: byte 0 = FF held until the ack, then exactly 42 bytes FF×6 000223010203 0806 0001 0800 06 04 0001 000223010203 C0A80102 00×6 C0A80101.
- Resolve: then send a reply with sender MAC 00014200 5F68, sender IP C0A80101, target IP C0A80102. Required: one-cycle `RESOLVED_VALID`, `RESOLVED_MAC`=0001_4200_5F68, `READY`=1 on the same cycle.
- Retry/fail: `TIMEOUT_CYCLES`=100, `MAX_RETRIES`=2, no reply, each TX acked. Required: 3 requests sent, each ≥100 cycles apart; one `RESOLVE_FAIL` pulse; no `RESOLVED_VALID`.
- Filtering: send in turn a reply from sender IP C0A80105, a frame with opcode 0001, and a 41-byte truncated reply. Required: all ignored and the timeout counter is not reset. A following correct reply resolves.
- Reset mid-TX: assert `ARESET` during byte 20. Required: `DATA_VALID_TX`=0 and `READY`=1 immediately; no pulses. A new request after release produces a full, correct frame.
- Tie: a reply's end evaluation coincides with timeout expiry. Required: `RESOLVED_VALID` pulse, no retransmit, no `RESOLVE_FAIL`.
